// File: rtl/elastic_pipe_chain.sv
// Elastic valid/ready register chain replacing fixed pipeline stage registers.
// Adds per-stage kill, global flush, bubble collapsing and an optional input skid slot.
module elastic_pipe_chain #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int SKID  = 1,
    localparam int CW   = $clog2(DEPTH + SKID + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic [DEPTH-1:0] flush,
    input  logic             flush_all,
    output logic [DEPTH-1:0] stage_valid,
    output logic [CW-1:0]    occupancy
);

    // Handshake: a beat transfers on an edge where valid and ready are both high;
    // valid never depends on ready, and a held beat stays put until it transfers.

    logic [DEPTH-1:0] v_q, v_d;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [WIDTH-1:0] d_d [DEPTH];
    logic             sv_q, sv_d;
    logic [WIDTH-1:0] sd_q, sd_d;
    logic [CW-1:0]    occ_q, occ_d;
    logic [DEPTH-1:0] r;
    logic             src_v;
    logic [WIDTH-1:0] src_d;

    // A stage can load whenever it is empty or everything above it can move.
    always_comb begin
        r = '0;
        r[DEPTH-1] = out_ready | ~v_q[DEPTH-1];
        for (int i = DEPTH - 2; i >= 0; i--) begin
            r[i] = r[i+1] | ~v_q[i];
        end
    end

    always_comb begin
        sv_d = sv_q;
        sd_d = sd_q;
        in_ready = r[0];
        src_v = in_valid;
        src_d = in_data;
        if (SKID != 0) begin
            // The skid beat is always older than in_data, so it feeds stage 0 first.
            in_ready = ~sv_q;
            src_v = sv_q | in_valid;
            src_d = sv_q ? sd_q : in_data;
            if (sv_q) begin
                if (r[0]) begin
                    sv_d = 1'b0;
                end
            end else if (in_valid && !r[0]) begin
                sv_d = 1'b1;
                sd_d = in_data;
            end
        end else begin
            sv_d = 1'b0;
        end

        v_d = v_q;
        d_d = d_q;
        if (r[0]) begin
            v_d[0] = src_v;
            d_d[0] = src_d;
        end else begin
            v_d[0] = v_q[0] & ~flush[0];
        end
        // A killed beat that moves up arrives as a bubble.
        for (int i = 1; i < DEPTH; i++) begin
            if (r[i]) begin
                v_d[i] = v_q[i-1] & ~flush[i-1];
                d_d[i] = d_q[i-1];
            end else begin
                v_d[i] = v_q[i] & ~flush[i];
            end
        end

        if (flush_all) begin
            v_d = '0;
            sv_d = 1'b0;
        end

        occ_d = CW'(sv_d);
        for (int i = 0; i < DEPTH; i++) begin
            occ_d = occ_d + CW'(v_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q   <= '0;
            sv_q  <= 1'b0;
            sd_q  <= '0;
            occ_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                d_q[i] <= '0;
            end
        end else begin
            v_q   <= v_d;
            sv_q  <= sv_d;
            sd_q  <= sd_d;
            occ_q <= occ_d;
            for (int i = 0; i < DEPTH; i++) begin
                d_q[i] <= d_d[i];
            end
        end
    end

    assign stage_valid = v_q;
    assign out_valid   = v_q[DEPTH-1];
    assign out_data    = d_q[DEPTH-1];
    assign occupancy   = occ_q;

endmodule

// File: tb/tb_elastic_pipe_chain.sv
// Directed bench for elastic_pipe_chain: a DEPTH=4/SKID=1 instance and a
// DEPTH=1/SKID=0 instance share stimulus; sel picks which one is observed.
module tb_elastic_pipe_chain;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic [3:0]  flush;
    logic        flush_all;

    logic        in_ready_a, out_valid_a;
    logic [31:0] out_data_a;
    logic [3:0]  stage_valid_a;
    logic [2:0]  occupancy_a;

    logic        in_ready_b, out_valid_b;
    logic [31:0] out_data_b;
    logic [0:0]  stage_valid_b;
    logic [0:0]  occupancy_b;

    logic        sel;
    logic        m_in_ready, m_out_valid;
    logic [31:0] m_out_data;
    logic [3:0]  m_stage_valid;
    logic [3:0]  m_occ;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int acc_n, first_acc, first_ov, first_out, last_out, occ_max;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    elastic_pipe_chain #(.WIDTH(32), .DEPTH(4), .SKID(1)) u_dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_data(out_data_a), .flush(flush), .flush_all(flush_all),
        .stage_valid(stage_valid_a), .occupancy(occupancy_a)
    );

    elastic_pipe_chain #(.WIDTH(32), .DEPTH(1), .SKID(0)) u_dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b), .flush(flush[0:0]), .flush_all(flush_all),
        .stage_valid(stage_valid_b), .occupancy(occupancy_b)
    );

    assign m_in_ready    = sel ? in_ready_b    : in_ready_a;
    assign m_out_valid   = sel ? out_valid_b   : out_valid_a;
    assign m_out_data    = sel ? out_data_b    : out_data_a;
    assign m_stage_valid = sel ? {3'b000, stage_valid_b} : stage_valid_a;
    assign m_occ         = sel ? {3'b000, occupancy_b}   : {1'b0, occupancy_a};

    // Handshakes are stable at the falling edge and complete at the next rising edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (in_valid && m_in_ready) begin
                acc_n++;
                if (first_acc < 0) first_acc = cyc + 1;
            end
            if (m_out_valid && first_ov < 0) first_ov = cyc;
            if (m_out_valid && out_ready) begin
                got_q.push_back(m_out_data);
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
            end
            if (int'(m_occ) > occ_max) occ_max = int'(m_occ);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s (sel=%0d): got %0h expected %0h", tag, sel, obs, exp);
        end
    endtask

    task automatic check_queue(input string tag);
        check_eq({tag, "_count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            check_eq({tag, "_beat"}, got_q.pop_front(), exp_q.pop_front());
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_out_valid"}, m_out_valid, 1'b0);
        check_eq({tag, "_out_data"}, m_out_data, 32'h0);
        check_eq({tag, "_stage_valid"}, m_stage_valid, 4'h0);
        check_eq({tag, "_occupancy"}, m_occ, 4'h0);
        check_eq({tag, "_in_ready"}, m_in_ready, 1'b1);
    endtask

    // ---------------- drivers ----------------
    task automatic clear_mon();
        acc_n = 0; first_acc = -1; first_ov = -1; first_out = -1; last_out = -1; occ_max = 0;
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic drive(input logic iv, input logic [31:0] id, input logic ordy,
                         input logic [3:0] fl, input logic fa);
        in_valid = iv; in_data = id; out_ready = ordy; flush = fl; flush_all = fa;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = '0; flush_all = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_mon();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int d, s, n_hold;
        sel = 1'b0;
        for (int t = 0; t < 2; t++) begin
            sel = (t == 1);
            d = sel ? 1 : 4;
            s = sel ? 0 : 1;

            do_reset();
            check_reset_vals("reset");

            // Streaming 1..10 with out_ready held high
            for (int k = 1; k <= 10; k++) drive(1'b1, 32'(k), 1'b1, 4'b0, 1'b0);
            for (int k = 0; k < 8; k++) drive(1'b0, 32'h0, 1'b1, 4'b0, 1'b0);
            for (int k = 1; k <= 10; k++) exp_q.push_back(32'(k));
            check_eq("stream_accepted", acc_n, 10);
            check_eq("stream_latency", first_ov - first_acc, d - 1);
            check_eq("stream_no_gaps", last_out - first_out, 9);
            check_eq("stream_occ_peak", occ_max, d);
            check_queue("stream");

            // Backpressure: stalled output absorbs DEPTH+SKID beats
            do_reset();
            for (int k = 0; k < 6; k++) drive(1'b1, 32'h30 + 32'(acc_n), 1'b0, 4'b0, 1'b0);
            check_eq("bp_accepted", acc_n, d + s);
            check_eq("bp_in_ready_low", m_in_ready, 1'b0);
            check_eq("bp_occupancy", m_occ, 4'(d + s));
            drive(1'b0, 32'h0, 1'b1, 4'b0, 1'b0);
            check_eq("bp_in_ready_back", m_in_ready, 1'b1);
            for (int k = 0; k < 10; k++) drive(1'b0, 32'h0, 1'b1, 4'b0, 1'b0);
            for (int k = 0; k < d + s; k++) exp_q.push_back(32'h30 + 32'(k));
            check_eq("bp_no_gaps", last_out - first_out, d + s - 1);
            check_queue("bp");

            if (!sel) begin
                // Bubble collapse: A - B - C with output stalled
                do_reset();
                drive(1'b1, 32'hA, 1'b0, 4'b0, 1'b0);
                drive(1'b0, 32'h0, 1'b0, 4'b0, 1'b0);
                drive(1'b1, 32'hB, 1'b0, 4'b0, 1'b0);
                drive(1'b0, 32'h0, 1'b0, 4'b0, 1'b0);
                drive(1'b1, 32'hC, 1'b0, 4'b0, 1'b0);
                for (int k = 0; k < 5; k++) drive(1'b0, 32'h0, 1'b0, 4'b0, 1'b0);
                check_eq("bubble_stage_valid", m_stage_valid, 4'b1110);
                check_eq("bubble_occupancy", m_occ, 4'd3);
                for (int k = 0; k < 8; k++) drive(1'b0, 32'h0, 1'b1, 4'b0, 1'b0);
                exp_q.push_back(32'hA); exp_q.push_back(32'hB); exp_q.push_back(32'hC);
                check_queue("bubble");

                // Per-stage flush of the middle two stages
                do_reset();
                for (int k = 4; k >= 1; k--) drive(1'b1, 32'(k), 1'b0, 4'b0, 1'b0);
                check_eq("flush_full", m_stage_valid, 4'b1111);
                drive(1'b0, 32'h0, 1'b0, 4'b0110, 1'b0);
                check_eq("flush_stage_valid", m_stage_valid, 4'b1001);
                check_eq("flush_occupancy", m_occ, 4'd2);
                drive(1'b1, 32'd5, 1'b1, 4'b0, 1'b0);
                drive(1'b1, 32'd6, 1'b1, 4'b0, 1'b0);
                for (int k = 0; k < 8; k++) drive(1'b0, 32'h0, 1'b1, 4'b0, 1'b0);
                exp_q.push_back(32'd4); exp_q.push_back(32'd1);
                exp_q.push_back(32'd5); exp_q.push_back(32'd6);
                check_queue("flush");
            end

            // flush_all with simultaneous input and output handshakes
            do_reset();
            drive(1'b1, 32'h70, 1'b0, 4'b0, 1'b0);
            for (int k = 0; k < d - 1; k++) drive(1'b0, 32'h0, 1'b0, 4'b0, 1'b0);
            check_eq("fa_out_valid_before", m_out_valid, 1'b1);
            drive(1'b1, 32'h99, 1'b1, 4'b0, 1'b1);
            check_eq("fa_occupancy", m_occ, 4'd0);
            check_eq("fa_out_valid", m_out_valid, 1'b0);
            check_eq("fa_accepted", acc_n, 2);
            for (int k = 0; k < 6; k++) drive(1'b0, 32'h0, 1'b1, 4'b0, 1'b0);
            exp_q.push_back(32'h70);
            check_queue("fa");

            // Reset mid-stream, then a fresh beat
            do_reset();
            n_hold = (d + s < 3) ? d + s : 3;
            for (int k = 0; k < 3; k++) drive(1'b1, 32'h40 + 32'(acc_n), 1'b0, 4'b0, 1'b0);
            check_eq("mid_occupancy", m_occ, 4'(n_hold));
            reset = 1'b1;
            drive(1'b0, 32'h0, 1'b0, 4'b0, 1'b0);
            reset = 1'b0;
            check_reset_vals("mid_reset");
            check_eq("mid_no_output", got_q.size(), 0);
            clear_mon();
            drive(1'b1, 32'h55, 1'b1, 4'b0, 1'b0);
            for (int k = 0; k < 8; k++) drive(1'b0, 32'h0, 1'b1, 4'b0, 1'b0);
            check_eq("mid_latency", first_ov - first_acc, d - 1);
            exp_q.push_back(32'h55);
            check_queue("mid");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
